branch_predictor: RTL and testbench

//  Parametrised dynamic branch predictor (BHT + BTB) for the 5-stage pipeline; successor to ID-stage

---
 rtl/branch_pred_pkg.sv | 21 ++
 rtl/branch_predictor_sat_counter.sv | 28 ++
 rtl/branch_predictor.sv | 162 ++++++++++++++++
 tb/tb_branch_predictor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pred_pkg.sv
// Shared constants and counter-initialisation helpers for the branch predictor.
package branch_pred_pkg;

   // Predictor operating modes
   localparam int MODE_STATIC  = 0;
   localparam int MODE_DYNAMIC = 1;

   // Widest saturating counter supported; helpers return this width
   localparam int CTR_MAX_W = 4;

   // Reset value: weakly not-taken, 2^(bits-1)-1
   function automatic logic [CTR_MAX_W-1:0] ctr_init(input int ctr_bits);
      ctr_init = CTR_MAX_W'((1 << (ctr_bits - 1)) - 1);
   endfunction

   // Allocation value: weakly taken, 2^(bits-1)
   function automatic logic [CTR_MAX_W-1:0] ctr_alloc(input int ctr_bits);
      ctr_alloc = CTR_MAX_W'(1 << (ctr_bits - 1));
   endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-value logic for a CTR_BITS-wide saturating up/down counter.
module sat_counter #(
   parameter int CTR_BITS = 2
) (
   input  logic [CTR_BITS-1:0] ctr_i,
   input  logic                up_i,
   output logic [CTR_BITS-1:0] ctr_o
);

   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
   localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

   // Step towards the requested direction, holding at either rail
   always_comb begin
      ctr_o = ctr_i;
      if (up_i) begin
         if (ctr_i != CTR_MAX) begin
            ctr_o = ctr_i + CTR_ONE;
         end
      end else begin
         if (ctr_i != CTR_MIN) begin
            ctr_o = ctr_i - CTR_ONE;
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB branch predictor. IF looks up a fetch PC with zero
// latency; ID reports resolved branches, which train the tables and raise a
// flush with a corrected PC when the carried prediction was wrong.
module branch_predictor
   import branch_pred_pkg::*;
#(
   parameter int PC_WIDTH = 32,
   parameter int ENTRIES  = 16,
   parameter int TAG_BITS = 8,
   parameter int CTR_BITS = 2,
   parameter int MODE     = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [PC_WIDTH-1:0] if_pc_i,
   output logic                pred_hit_o,
   output logic                pred_taken_o,
   output logic [PC_WIDTH-1:0] pred_target_o,
   input  logic                upd_valid_i,
   input  logic [PC_WIDTH-1:0] upd_pc_i,
   input  logic                upd_taken_i,
   input  logic [PC_WIDTH-1:0] upd_target_i,
   input  logic                upd_pred_taken_i,
   input  logic [PC_WIDTH-1:0] upd_pred_target_i,
   output logic                flush_o,
   output logic [PC_WIDTH-1:0] redirect_pc_o,
   output logic [31:0]         mispred_cnt_o
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = TAG_LO + TAG_BITS - 1;

   localparam logic [CTR_MAX_W-1:0] CTR_INIT_FULL  = ctr_init(CTR_BITS);
   localparam logic [CTR_MAX_W-1:0] CTR_ALLOC_FULL = ctr_alloc(CTR_BITS);
   localparam logic [CTR_BITS-1:0]  CTR_INIT       = CTR_INIT_FULL[CTR_BITS-1:0];
   localparam logic [CTR_BITS-1:0]  CTR_ALLOC      = CTR_ALLOC_FULL[CTR_BITS-1:0];

   localparam logic [PC_WIDTH-1:0]  PC_STEP = PC_WIDTH'(4);
   localparam logic [31:0]          CNT_MAX = '1;
   localparam logic                 DYNAMIC = (MODE == MODE_DYNAMIC);

   // Prediction tables
   logic                valid_q  [ENTRIES];
   logic                valid_d  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [TAG_BITS-1:0] tag_d    [ENTRIES];
   logic [PC_WIDTH-1:0] target_q [ENTRIES];
   logic [PC_WIDTH-1:0] target_d [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
   logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

   logic [31:0]         mispred_cnt_q;
   logic [31:0]         mispred_cnt_d;

   logic [IDX_W-1:0]    lk_idx;
   logic [TAG_BITS-1:0] lk_tag;
   logic                lk_hit;

   logic [IDX_W-1:0]    up_idx;
   logic [TAG_BITS-1:0] up_tag;
   logic                up_hit;
   logic                up_en;
   logic [CTR_BITS-1:0] ctr_upd;

   // Bits [1:0] and any bits above the tag never select or qualify an entry
   logic                unused_pc_bits;
   assign unused_pc_bits = ^{if_pc_i, upd_pc_i};

   // Fetch-side lookup: reads registered tables, so a same-cycle update is not visible yet
   always_comb begin
      lk_idx        = if_pc_i[IDX_W+1:2];
      lk_tag        = if_pc_i[TAG_HI:TAG_LO];
      lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_hit_o    = lk_hit;
      pred_taken_o  = DYNAMIC && lk_hit && ctr_q[lk_idx][CTR_BITS-1];
      pred_target_o = pred_taken_o ? target_q[lk_idx] : (if_pc_i + PC_STEP);
   end

   // Mispredict detection is purely a function of the resolved branch, never of start_i or MODE
   always_comb begin
      flush_o       = upd_valid_i &&
                      ((upd_taken_i != upd_pred_taken_i) ||
                       (upd_taken_i && (upd_target_i != upd_pred_target_i)));
      redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + PC_STEP);
   end

   // Training address decode and hit detection for the resolved branch
   always_comb begin
      up_idx = upd_pc_i[IDX_W+1:2];
      up_tag = upd_pc_i[TAG_HI:TAG_LO];
      up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_en  = start_i && upd_valid_i && DYNAMIC;
   end

   sat_counter #(
      .CTR_BITS (CTR_BITS)
   ) u_sat_counter (
      .ctr_i (ctr_q[up_idx]),
      .up_i  (upd_taken_i),
      .ctr_o (ctr_upd)
   );

   // Table next-state: train on hit, allocate on taken miss, ignore not-taken miss
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (up_en) begin
         if (up_hit) begin
            ctr_d[up_idx] = ctr_upd;
            if (upd_taken_i) begin
               target_d[up_idx] = upd_target_i;
            end
         end else if (upd_taken_i) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target_i;
            ctr_d[up_idx]    = CTR_ALLOC;
         end
      end
   end

   // Mispredict statistics, saturating at all-ones
   always_comb begin
      mispred_cnt_d = mispred_cnt_q;
      if (start_i && flush_o && (mispred_cnt_q != CNT_MAX)) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   assign mispred_cnt_o = mispred_cnt_q;

   // Table storage; reset wipes every entry so nothing in flight survives
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_INIT;
         end
      end else begin
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
         ctr_q    <= ctr_d;
      end
   end

   // Mispredict counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mispred_cnt_q <= '0;
      end else begin
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a dynamic and a static instance share stimulus;
// a table-level model predicts every output each cycle, and directed steps
// pin the model with hand-computed literals.
module tb_branch_predictor;

   localparam int ENTRIES  = 16;
   localparam int IDX_W    = 4;
   localparam int TAG_BITS = 8;
   localparam int CTR_BITS = 2;
   localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
   localparam int CTR_HALF = 1 << (CTR_BITS - 1);

   bit          clk;
   bit          rst;
   logic        start;
   logic [31:0] if_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;

   logic        d_hit, d_taken, d_flush;
   logic [31:0] d_target, d_redirect, d_cnt;
   logic        s_hit, s_taken, s_flush;
   logic [31:0] s_target, s_redirect, s_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predictor #(
      .PC_WIDTH (32), .ENTRIES (ENTRIES), .TAG_BITS (TAG_BITS), .CTR_BITS (CTR_BITS), .MODE (1)
   ) dut (
      .clk_i (clk), .rst_i (rst), .start_i (start), .if_pc_i (if_pc),
      .pred_hit_o (d_hit), .pred_taken_o (d_taken), .pred_target_o (d_target),
      .upd_valid_i (upd_valid), .upd_pc_i (upd_pc), .upd_taken_i (upd_taken),
      .upd_target_i (upd_target), .upd_pred_taken_i (upd_pred_taken),
      .upd_pred_target_i (upd_pred_target),
      .flush_o (d_flush), .redirect_pc_o (d_redirect), .mispred_cnt_o (d_cnt)
   );

   branch_predictor #(
      .PC_WIDTH (32), .ENTRIES (ENTRIES), .TAG_BITS (TAG_BITS), .CTR_BITS (CTR_BITS), .MODE (0)
   ) dut_static (
      .clk_i (clk), .rst_i (rst), .start_i (start), .if_pc_i (if_pc),
      .pred_hit_o (s_hit), .pred_taken_o (s_taken), .pred_target_o (s_target),
      .upd_valid_i (upd_valid), .upd_pc_i (upd_pc), .upd_taken_i (upd_taken),
      .upd_target_i (upd_target), .upd_pred_taken_i (upd_pred_taken),
      .upd_pred_target_i (upd_pred_target),
      .flush_o (s_flush), .redirect_pc_o (s_redirect), .mispred_cnt_o (s_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_valid  [ENTRIES];
   int          m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   longint      m_cnt;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic int tag_of(input logic [31:0] pc);
      return int'((pc >> (IDX_W + 2)) % (1 << TAG_BITS));
   endfunction

   function automatic bit m_flush();
      return upd_valid && ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_target != upd_pred_target)));
   endfunction

   function automatic logic [31:0] m_redirect();
      return upd_taken ? upd_target : (upd_pc + 32'd4);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k]  <= 0;
            m_tag[k]    <= 0;
            m_target[k] <= 32'd0;
            m_ctr[k]    <= CTR_HALF - 1;
         end
         m_cnt <= 0;
      end else begin
         if (start && m_flush() && (m_cnt < 64'h0000_0000_FFFF_FFFF))
            m_cnt <= m_cnt + 1;
         if (start && upd_valid) begin
            if ((m_valid[idx_of(upd_pc)] != 0) && (m_tag[idx_of(upd_pc)] == tag_of(upd_pc))) begin
               if (upd_taken) begin
                  m_ctr[idx_of(upd_pc)]    <= (m_ctr[idx_of(upd_pc)] < CTR_TOP) ?
                                              m_ctr[idx_of(upd_pc)] + 1 : CTR_TOP;
                  m_target[idx_of(upd_pc)] <= upd_target;
               end else begin
                  m_ctr[idx_of(upd_pc)]    <= (m_ctr[idx_of(upd_pc)] > 0) ?
                                              m_ctr[idx_of(upd_pc)] - 1 : 0;
               end
            end else if (upd_taken) begin
               m_valid[idx_of(upd_pc)]  <= 1;
               m_tag[idx_of(upd_pc)]    <= tag_of(upd_pc);
               m_target[idx_of(upd_pc)] <= upd_target;
               m_ctr[idx_of(upd_pc)]    <= CTR_HALF;
            end
         end
      end
   end

   // Per-cycle comparison on the falling edge
   bit          e_hit, e_taken;
   logic [31:0] e_target;
   always @(negedge clk) begin
      e_hit    = (m_valid[idx_of(if_pc)] != 0) && (m_tag[idx_of(if_pc)] == tag_of(if_pc));
      e_taken  = e_hit && (m_ctr[idx_of(if_pc)] >= CTR_HALF);
      e_target = e_taken ? m_target[idx_of(if_pc)] : (if_pc + 32'd4);
      chk("dyn_hit",      32'(d_hit),   32'(e_hit));
      chk("dyn_taken",    32'(d_taken), 32'(e_taken));
      chk("dyn_target",   d_target,     e_target);
      chk("dyn_flush",    32'(d_flush), 32'(m_flush()));
      chk("dyn_redirect", d_redirect,   m_redirect());
      chk("dyn_cnt",      d_cnt,        32'(m_cnt));
      chk("sta_hit",      32'(s_hit),   32'd0);
      chk("sta_taken",    32'(s_taken), 32'd0);
      chk("sta_target",   s_target,     if_pc + 32'd4);
      chk("sta_flush",    32'(s_flush), 32'(m_flush()));
      chk("sta_redirect", s_redirect,   m_redirect());
      chk("sta_cnt",      s_cnt,        32'(m_cnt));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      upd_valid       = 1'b1;
      upd_pc          = pc;
      upd_taken       = tk;
      upd_target      = tgt;
      upd_pred_taken  = ptk;
      upd_pred_target = ptgt;
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b1;
      if_pc = 32'd0;
      upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
      upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
      #1 rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // 1: empty tables after reset
      if_pc = 32'h40; #1;
      chk("t1_hit",    32'(d_hit),   32'd0);
      chk("t1_taken",  32'(d_taken), 32'd0);
      chk("t1_target", d_target,     32'h44);
      chk("t1_cnt",    d_cnt,        32'd0);

      // 2: allocate, decay to strongly not-taken, saturate at top
      tick();
      set_upd(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      tick(); upd_valid = 1'b0; #1;
      chk("t2_alloc_hit",    32'(d_hit),   32'd1);
      chk("t2_alloc_taken",  32'(d_taken), 32'd1);
      chk("t2_alloc_target", d_target,     32'h80);
      chk("t2_alloc_cnt",    d_cnt,        32'd1);
      set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      repeat (3) tick();
      upd_valid = 1'b0; #1;
      chk("t2_nt_hit",    32'(d_hit),   32'd1);
      chk("t2_nt_taken",  32'(d_taken), 32'd0);
      chk("t2_nt_target", d_target,     32'h44);
      set_upd(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      repeat (5) tick();
      upd_valid = 1'b0; #1;
      chk("t2_t_taken", 32'(d_taken), 32'd1);
      chk("t2_t_cnt",   d_cnt,        32'd1);
      set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(); upd_valid = 1'b0; #1;
      chk("t2_sat_one_down", 32'(d_taken), 32'd1);
      set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      tick(); upd_valid = 1'b0; #1;
      chk("t2_sat_two_down", 32'(d_taken), 32'd0);

      // 3: mispredict flush, redirect and statistics
      set_upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200); #1;
      chk("t3_flush",    32'(d_flush), 32'd1);
      chk("t3_redirect", d_redirect,   32'h104);
      tick(); upd_valid = 1'b0; #1;
      chk("t3_cnt_inc", d_cnt, 32'd2);
      set_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0); #1;
      chk("t3_ok_flush", 32'(d_flush), 32'd0);
      tick(); upd_valid = 1'b0; #1;
      chk("t3_ok_cnt", d_cnt, 32'd2);
      set_upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h200); #1;
      chk("t3_tgt_flush",    32'(d_flush), 32'd1);
      chk("t3_tgt_redirect", d_redirect,   32'h300);
      tick(); upd_valid = 1'b0; #1;
      chk("t3_tgt_cnt", d_cnt, 32'd3);

      // 4: aliasing index with a different tag
      if_pc = 32'h80; #1;
      chk("t4_alias_hit",    32'(d_hit), 32'd0);
      chk("t4_alias_target", d_target,   32'h84);
      set_upd(32'h80, 1'b1, 32'h500, 1'b0, 32'h0);
      tick(); upd_valid = 1'b0; #1;
      chk("t4_repl_hit",    32'(d_hit),   32'd1);
      chk("t4_repl_taken",  32'(d_taken), 32'd1);
      chk("t4_repl_target", d_target,     32'h500);
      chk("t4_repl_cnt",    d_cnt,        32'd4);
      if_pc = 32'h40; #1;
      chk("t4_old_evicted", 32'(d_hit), 32'd0);

      // 5: read-before-write, then start_i gating
      if_pc = 32'h80;
      set_upd(32'h80, 1'b0, 32'h0, 1'b1, 32'h500); #1;
      chk("t5_pre_taken",  32'(d_taken), 32'd1);
      chk("t5_pre_target", d_target,     32'h500);
      chk("t5_pre_flush",  32'(d_flush), 32'd1);
      tick(); upd_valid = 1'b0; #1;
      chk("t5_post_taken",  32'(d_taken), 32'd0);
      chk("t5_post_target", d_target,     32'h84);
      chk("t5_post_cnt",    d_cnt,        32'd5);
      start = 1'b0;
      set_upd(32'h80, 1'b1, 32'h600, 1'b0, 32'h0); #1;
      chk("t5_idle_flush",    32'(d_flush), 32'd1);
      chk("t5_idle_redirect", d_redirect,   32'h600);
      tick(); upd_valid = 1'b0; #1;
      chk("t5_idle_taken", 32'(d_taken), 32'd0);
      chk("t5_idle_cnt",   d_cnt,        32'd5);
      start = 1'b1;

      // 6: static mode instance, then reset mid-training
      #1;
      chk("t6_static_hit",    32'(s_hit),   32'd0);
      chk("t6_static_taken",  32'(s_taken), 32'd0);
      chk("t6_static_target", s_target,     32'h84);
      chk("t6_static_cnt",    s_cnt,        32'd5);
      set_upd(32'h80, 1'b1, 32'h700, 1'b1, 32'h500);
      rst = 1'b1; #1;
      chk("t6_rst_hit", 32'(d_hit), 32'd0);
      chk("t6_rst_cnt", d_cnt,      32'd0);
      tick();
      rst = 1'b0; upd_valid = 1'b0; #1;
      chk("t6_after_hit", 32'(d_hit), 32'd0);
      chk("t6_after_cnt", d_cnt,      32'd0);
      if_pc = 32'h40; #1;
      chk("t6_after_hit40", 32'(d_hit), 32'd0);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
